// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED codec: injection mode encodings and
// elaboration-time helpers that describe the Hamming code layout.
package ecc_pkg;

  localparam logic [1:0] INJ_NONE   = 2'd0;
  localparam logic [1:0] INJ_SINGLE = 2'd1;
  localparam logic [1:0] INJ_DOUBLE = 2'd2;

  // Smallest r such that 2^r >= dw + r + 1.
  function automatic int calc_hamwidth(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << r) < dw + r + 1) r = r + 1;
    end
    return r;
  endfunction

  // True for Hamming positions that carry a parity bit.
  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Code bit index (Hamming position - 1) that holds data bit n.
  function automatic int data_pos(input int n);
    int cnt;
    int res;
    bit found;
    cnt   = 0;
    res   = 0;
    found = 1'b0;
    for (int pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == n && !found) begin
          res   = pos - 1;
          found = 1'b1;
        end
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational Hamming syndrome and overall parity of a code word.
// The syndrome XORs the Hamming position of every set bit among code bits
// 0..N-2, so it covers parity positions as well as data positions.
module ecc_syndrome
  import ecc_pkg::*;
#(
  parameter  int P_DATAWIDTH = 32,
  localparam int P_HAMWIDTH  = calc_hamwidth(P_DATAWIDTH),
  localparam int P_CODEWIDTH = P_DATAWIDTH + P_HAMWIDTH + 1
) (
  input  logic [P_CODEWIDTH-1:0] code,
  output logic [P_HAMWIDTH-1:0]  syndrome,
  output logic                   parity
);

  // Accumulate positions of set bits and the parity of the whole word.
  always_comb begin
    syndrome = '0;
    for (int i = 0; i < P_CODEWIDTH - 1; i++) begin
      if (code[i]) syndrome = syndrome ^ P_HAMWIDTH'(i + 1);
    end
    parity = ^code;
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Pipelined SECDED codec: registered encoder with fault injection, 2-stage
// decoder with correction/detection flags and saturating error counters.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. A producer holding valid keeps its payload
// stable until that edge; ready may depend combinationally on the
// downstream ready, but valid never depends on ready.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter  int P_DATAWIDTH   = 32,
  parameter  int P_CNTWIDTH    = 16,
  localparam int P_HAMWIDTH    = calc_hamwidth(P_DATAWIDTH),
  localparam int P_PARITYWIDTH = P_HAMWIDTH + 1,
  localparam int P_CODEWIDTH   = P_DATAWIDTH + P_PARITYWIDTH,
  localparam int P_POSWIDTH    = $clog2(P_CODEWIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enc_in_valid,
  output logic                   enc_in_ready,
  input  logic [P_DATAWIDTH-1:0] enc_in_data,
  output logic                   enc_out_valid,
  input  logic                   enc_out_ready,
  output logic [P_CODEWIDTH-1:0] enc_out_code,
  input  logic [1:0]             inj_mode,
  input  logic [P_POSWIDTH-1:0]  inj_pos0,
  input  logic [P_POSWIDTH-1:0]  inj_pos1,
  input  logic                   dec_in_valid,
  output logic                   dec_in_ready,
  input  logic [P_CODEWIDTH-1:0] dec_in_code,
  output logic                   dec_out_valid,
  input  logic                   dec_out_ready,
  output logic [P_DATAWIDTH-1:0] dec_out_data,
  output logic                   dec_out_sec,
  output logic                   dec_out_ded,
  output logic [P_HAMWIDTH-1:0]  dec_out_syndrome,
  input  logic                   cnt_clr,
  output logic [P_CNTWIDTH-1:0]  sec_cnt,
  output logic [P_CNTWIDTH-1:0]  ded_cnt
);

  // ---------------- encoder ----------------
  logic [P_CODEWIDTH-1:0] enc_raw;
  logic [P_CODEWIDTH-1:0] enc_code_nxt;
  logic [P_CODEWIDTH-1:0] inj_mask;
  logic [P_HAMWIDTH-1:0]  enc_syn;
  logic                   enc_par;

  // Scatter data into its Hamming positions with parity slots left zero.
  always_comb begin
    enc_raw = '0;
    for (int n = 0; n < P_DATAWIDTH; n++) begin
      enc_raw[data_pos(n)] = enc_in_data[n];
    end
  end

  // With parity slots zero, the syndrome bits are exactly the parity bits.
  ecc_syndrome #(.P_DATAWIDTH(P_DATAWIDTH)) u_enc_syn (
    .code     (enc_raw),
    .syndrome (enc_syn),
    .parity   (enc_par)
  );

  // Insert parity bits; overall bit = data parity XOR Hamming parity bits.
  always_comb begin
    enc_code_nxt = enc_raw;
    for (int k = 0; k < P_HAMWIDTH; k++) begin
      enc_code_nxt[(1 << k) - 1] = enc_syn[k];
    end
    enc_code_nxt[P_CODEWIDTH-1] = enc_par ^ (^enc_syn);
  end

  // Injection mask; OR-ing makes equal positions a single flip.
  always_comb begin
    inj_mask = '0;
    case (inj_mode)
      INJ_SINGLE: begin
        if (int'(inj_pos0) < P_CODEWIDTH) inj_mask[inj_pos0] = 1'b1;
      end
      INJ_DOUBLE: begin
        if (int'(inj_pos0) < P_CODEWIDTH) inj_mask[inj_pos0] = 1'b1;
        if (int'(inj_pos1) < P_CODEWIDTH) inj_mask[inj_pos1] = 1'b1;
      end
      default: inj_mask = '0;
    endcase
  end

  assign enc_in_ready = !enc_out_valid || enc_out_ready;

  // Encoder output register: loads whenever the slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_valid <= 1'b0;
      enc_out_code  <= '0;
    end else if (enc_in_ready) begin
      enc_out_valid <= enc_in_valid;
      if (enc_in_valid) enc_out_code <= enc_code_nxt ^ inj_mask;
    end
  end

  // ---------------- decoder ----------------
  logic [P_HAMWIDTH-1:0]  dec_syn;
  logic                   dec_par;
  logic                   s1_valid;
  logic [P_CODEWIDTH-1:0] s1_code;
  logic [P_HAMWIDTH-1:0]  s1_syn;
  logic                   s1_par;
  logic                   ld1;
  logic                   ld2;
  logic [P_CODEWIDTH-1:0] cls_code;
  logic [P_DATAWIDTH-1:0] cls_data;
  logic                   cls_sec;
  logic                   cls_ded;

  ecc_syndrome #(.P_DATAWIDTH(P_DATAWIDTH)) u_dec_syn (
    .code     (dec_in_code),
    .syndrome (dec_syn),
    .parity   (dec_par)
  );

  assign ld2          = !dec_out_valid || dec_out_ready;
  assign ld1          = !s1_valid || ld2;
  assign dec_in_ready = ld1;

  // Stage 1: capture code with its syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (ld1) begin
      s1_valid <= dec_in_valid;
      if (dec_in_valid) begin
        s1_code <= dec_in_code;
        s1_syn  <= dec_syn;
        s1_par  <= dec_par;
      end
    end
  end

  // Classify the stage-1 word, correct a single error, extract data.
  always_comb begin
    cls_code = s1_code;
    cls_sec  = 1'b0;
    cls_ded  = 1'b0;
    if (s1_par) begin
      if (s1_syn == '0) begin
        cls_sec = 1'b1;
      end else if (int'(s1_syn) <= P_CODEWIDTH - 1) begin
        cls_code[s1_syn - P_HAMWIDTH'(1)] = ~s1_code[s1_syn - P_HAMWIDTH'(1)];
        cls_sec = 1'b1;
      end else begin
        cls_ded = 1'b1;
      end
    end else if (s1_syn != '0) begin
      cls_ded = 1'b1;
    end
    cls_data = '0;
    for (int n = 0; n < P_DATAWIDTH; n++) begin
      cls_data[n] = cls_code[data_pos(n)];
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out_valid    <= 1'b0;
      dec_out_data     <= '0;
      dec_out_sec      <= 1'b0;
      dec_out_ded      <= 1'b0;
      dec_out_syndrome <= '0;
    end else if (ld2) begin
      dec_out_valid <= s1_valid;
      if (s1_valid) begin
        dec_out_data     <= cls_data;
        dec_out_sec      <= cls_sec;
        dec_out_ded      <= cls_ded;
        dec_out_syndrome <= s1_syn;
      end
    end
  end

  // ---------------- counters ----------------
  logic dec_xfer;
  logic sec_inc;
  logic ded_inc;

  assign dec_xfer = dec_out_valid && dec_out_ready;
  assign sec_inc  = dec_xfer && dec_out_sec;
  assign ded_inc  = dec_xfer && dec_out_ded;

  // Saturating counters; a clear coinciding with a counted word leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (cnt_clr)                      sec_cnt <= sec_inc ? P_CNTWIDTH'(1) : '0;
      else if (sec_inc && sec_cnt != '1) sec_cnt <= sec_cnt + P_CNTWIDTH'(1);
      if (cnt_clr)                      ded_cnt <= ded_inc ? P_CNTWIDTH'(1) : '0;
      else if (ded_inc && ded_cnt != '1) ded_cnt <= ded_cnt + P_CNTWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Testbench for ecc_secded_pipe (32-bit data, 39-bit code, 16-bit counters).
module tb_ecc_secded_pipe;

  logic        clk;
  logic        rst_n;
  logic        enc_in_valid;
  logic        enc_in_ready;
  logic [31:0] enc_in_data;
  logic        enc_out_valid;
  logic        enc_out_ready;
  logic [38:0] enc_out_code;
  logic [1:0]  inj_mode;
  logic [5:0]  inj_pos0;
  logic [5:0]  inj_pos1;
  logic        dec_in_valid;
  logic        dec_in_ready;
  logic [38:0] dec_in_code;
  logic        dec_out_valid;
  logic        dec_out_ready;
  logic [31:0] dec_out_data;
  logic        dec_out_sec;
  logic        dec_out_ded;
  logic [5:0]  dec_out_syndrome;
  logic        cnt_clr;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;

  ecc_secded_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enc_in_valid     (enc_in_valid),
    .enc_in_ready     (enc_in_ready),
    .enc_in_data      (enc_in_data),
    .enc_out_valid    (enc_out_valid),
    .enc_out_ready    (enc_out_ready),
    .enc_out_code     (enc_out_code),
    .inj_mode         (inj_mode),
    .inj_pos0         (inj_pos0),
    .inj_pos1         (inj_pos1),
    .dec_in_valid     (dec_in_valid),
    .dec_in_ready     (dec_in_ready),
    .dec_in_code      (dec_in_code),
    .dec_out_valid    (dec_out_valid),
    .dec_out_ready    (dec_out_ready),
    .dec_out_data     (dec_out_data),
    .dec_out_sec      (dec_out_sec),
    .dec_out_ded      (dec_out_ded),
    .dec_out_syndrome (dec_out_syndrome),
    .cnt_clr          (cnt_clr),
    .sec_cnt          (sec_cnt),
    .ded_cnt          (ded_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Code bit i is Hamming position i+1; powers of two carry parity.
  function automatic logic [38:0] m_encode(input logic [31:0] d, input logic [1:0] mode,
                                           input int p0, input int p1);
    logic [38:0] c;
    int n;
    logic par;
    c = '0;
    n = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 38; pos++) if (((pos >> k) & 1) == 1) par ^= c[pos-1];
      c[(1 << k) - 1] = par;
    end
    c[38] = ^c[37:0];
    if (mode == 2'd1 && p0 < 39) c[p0] = ~c[p0];
    if (mode == 2'd2) begin
      if (p0 < 39) c[p0] = ~c[p0];
      if (p1 != p0 && p1 < 39) c[p1] = ~c[p1];
    end
    return c;
  endfunction

  // Returns {data, sec, ded, syndrome}.
  function automatic logic [39:0] m_decode(input logic [38:0] code);
    int s;
    logic p;
    logic [38:0] corr;
    logic [31:0] d;
    logic sec;
    logic ded;
    int n;
    s = 0;
    for (int pos = 1; pos <= 38; pos++) if (code[pos-1]) s = s ^ pos;
    p = ^code;
    corr = code;
    sec = 1'b0;
    ded = 1'b0;
    if (p) begin
      if (s == 0) sec = 1'b1;
      else if (s <= 38) begin
        corr[s-1] = ~corr[s-1];
        sec = 1'b1;
      end else ded = 1'b1;
    end else if (s != 0) ded = 1'b1;
    n = 0;
    d = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[n] = corr[pos-1];
        n++;
      end
    end
    return {d, sec, ded, s[5:0]};
  endfunction

  function automatic logic [38:0] gen_code();
    logic [38:0] c;
    int k;
    int a;
    int b;
    c = m_encode($urandom(), 2'd0, 0, 0);
    k = $urandom_range(0, 4);
    a = $urandom_range(0, 38);
    b = (a + $urandom_range(1, 38)) % 39;
    case (k)
      1: c[a] = ~c[a];
      2: begin c[a] = ~c[a]; c[b] = ~c[b]; end
      3: c = 39'({$urandom(), $urandom()});
      4: c[38] = ~c[38];
      default: ;
    endcase
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  logic [38:0] enc_exp_q[$];
  logic [39:0] dec_exp_q[$];
  logic [15:0] sec_exp = '0;
  logic [15:0] ded_exp = '0;
  logic        mon_en = 1'b0;
  logic        enc_hold = 1'b0;
  logic [38:0] enc_hold_code;
  logic        dec_hold = 1'b0;
  logic [39:0] dec_hold_val;
  int          dec_xfer_cnt = 0;

  // Sample at the falling edge; the rising edge that follows commits
  // whatever transfers are visible here.
  always @(negedge clk) begin
    logic [39:0] e;
    logic sec_i;
    logic ded_i;
    if (mon_en && rst_n) begin
      check("sec_cnt", sec_cnt, sec_exp);
      check("ded_cnt", ded_cnt, ded_exp);
      check("enc_in_ready", enc_in_ready, !enc_out_valid || enc_out_ready);

      if (enc_hold) begin
        check("enc_hold_valid", enc_out_valid, 1'b1);
        check("enc_hold_code", enc_out_code, enc_hold_code);
      end
      enc_hold = enc_out_valid && !enc_out_ready;
      enc_hold_code = enc_out_code;
      if (enc_out_valid && enc_out_ready) begin
        if (enc_exp_q.size() == 0) fail_now("enc_unexpected_output");
        else check("enc_code", enc_out_code, enc_exp_q.pop_front());
      end
      if (enc_in_valid && enc_in_ready)
        enc_exp_q.push_back(m_encode(enc_in_data, inj_mode, int'(inj_pos0), int'(inj_pos1)));

      if (dec_hold) begin
        check("dec_hold_valid", dec_out_valid, 1'b1);
        check("dec_hold_out", {dec_out_data, dec_out_sec, dec_out_ded, dec_out_syndrome}, dec_hold_val);
      end
      dec_hold = dec_out_valid && !dec_out_ready;
      dec_hold_val = {dec_out_data, dec_out_sec, dec_out_ded, dec_out_syndrome};
      sec_i = 1'b0;
      ded_i = 1'b0;
      if (dec_out_valid && dec_out_ready) begin
        dec_xfer_cnt++;
        if (dec_exp_q.size() == 0) fail_now("dec_unexpected_output");
        else begin
          e = dec_exp_q.pop_front();
          check("dec_data", dec_out_data, e[39:8]);
          check("dec_sec", dec_out_sec, e[7]);
          check("dec_ded", dec_out_ded, e[6]);
          check("dec_syndrome", dec_out_syndrome, e[5:0]);
          sec_i = e[7];
          ded_i = e[6];
        end
      end
      if (dec_in_valid && dec_in_ready) dec_exp_q.push_back(m_decode(dec_in_code));

      if (cnt_clr) sec_exp = sec_i ? 16'd1 : 16'd0;
      else if (sec_i && sec_exp != 16'hFFFF) sec_exp = sec_exp + 16'd1;
      if (cnt_clr) ded_exp = ded_i ? 16'd1 : 16'd0;
      else if (ded_i && ded_exp != 16'hFFFF) ded_exp = ded_exp + 16'd1;
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      enc_out_ready = ($urandom_range(0, 3) != 0);
      dec_out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr       = ($urandom_range(0, 31) == 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic enc_send(input logic [31:0] d, input logic [1:0] m, input logic [5:0] p0, input logic [5:0] p1);
    logic acc;
    int guard;
    enc_in_valid = 1'b1;
    enc_in_data  = d;
    inj_mode     = m;
    inj_pos0     = p0;
    inj_pos1     = p1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = enc_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) fail_now("enc_accept_timeout");
    enc_in_valid = 1'b0;
  endtask

  task automatic dec_send(input logic [38:0] c);
    logic acc;
    int guard;
    dec_in_valid = 1'b1;
    dec_in_code  = c;
    guard = 0;
    do begin
      @(negedge clk);
      acc = dec_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) fail_now("dec_accept_timeout");
    dec_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((enc_exp_q.size() != 0 || dec_exp_q.size() != 0 || enc_out_valid || dec_out_valid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int guard;
    rst_n = 1'b0;
    enc_in_valid = 1'b0; enc_in_data = '0; enc_out_ready = 1'b0;
    inj_mode = 2'd0; inj_pos0 = '0; inj_pos1 = '0;
    dec_in_valid = 1'b0; dec_in_code = '0; dec_out_ready = 1'b0;
    cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enc_valid", enc_out_valid, 1'b0);
    check("rst_enc_code", enc_out_code, 39'h0);
    check("rst_dec_valid", dec_out_valid, 1'b0);
    check("rst_dec_data", dec_out_data, 32'h0);
    check("rst_dec_flags", {dec_out_sec, dec_out_ded, dec_out_syndrome}, 8'h0);
    check("rst_cnts", {sec_cnt, ded_cnt}, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    enc_out_ready = 1'b1;
    dec_out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Encode 1: code appears one cycle after acceptance.
    enc_in_valid = 1'b1; enc_in_data = 32'h1; inj_mode = 2'd0;
    @(negedge clk);
    check("enc_accept", enc_in_ready, 1'b1);
    @(posedge clk);
    #1;
    enc_in_valid = 1'b0;
    @(negedge clk);
    check("enc_lat_valid", enc_out_valid, 1'b1);
    check("enc_lat_code", enc_out_code, 39'h40_0000_0007);
    @(posedge clk);
    #1;

    // Decode with code bit 5 flipped: corrected, syndrome 6, latency 2.
    dec_in_valid = 1'b1; dec_in_code = 39'h40_0000_0027;
    @(negedge clk);
    check("dec_accept", dec_in_ready, 1'b1);
    @(posedge clk);
    #1;
    dec_in_valid = 1'b0;
    @(negedge clk);
    check("dec_lat1_valid", dec_out_valid, 1'b0);
    @(negedge clk);
    check("dec_lat2_valid", dec_out_valid, 1'b1);
    check("sec_word_data", dec_out_data, 32'h1);
    check("sec_word_flags", {dec_out_sec, dec_out_ded}, 2'b10);
    check("sec_word_syn", dec_out_syndrome, 6'd6);
    @(negedge clk);
    check("sec_cnt_one", sec_cnt, 16'd1);
    @(posedge clk);
    #1;

    // Double injection at bits 5 and 10, then decode that word.
    enc_send(32'h1, 2'd2, 6'd5, 6'd10);
    @(negedge clk);
    check("enc_double_code", enc_out_code, 39'h40_0000_0427);
    @(posedge clk);
    #1;
    dec_send(39'h40_0000_0427);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!dec_out_valid && guard < 10);
    check("ded_word_data", dec_out_data, 32'h45);
    check("ded_word_flags", {dec_out_sec, dec_out_ded}, 2'b01);
    check("ded_word_syn", dec_out_syndrome, 6'd13);
    @(negedge clk);
    check("ded_cnt_one", ded_cnt, 16'd1);
    @(posedge clk);
    #1;

    // Eight back-to-back words with a 3-cycle output stall mid-stream.
    base = dec_xfer_cnt;
    fork
      for (int i = 0; i < 8; i++) dec_send(gen_code());
      begin
        repeat (4) @(posedge clk);
        #1;
        dec_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dec_out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_word_count", dec_xfer_cnt - base, 8);

    // Random traffic on both paths with random backpressure and clears.
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        enc_send($urandom(), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        dec_send(gen_code());
      end
    join
    rand_ready = 1'b0;
    enc_out_ready = 1'b1;
    dec_out_ready = 1'b1;
    cnt_clr = 1'b0;
    wait_drain();

    // Clear alone, then saturate sec_cnt.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_alone", sec_cnt, 16'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 65535; i++) dec_send(m_encode($urandom(), 2'd1, $urandom_range(0, 38), 0));
    wait_drain();
    check("sec_cnt_full", sec_cnt, 16'hFFFF);
    dec_send(m_encode($urandom(), 2'd1, $urandom_range(0, 38), 0));
    wait_drain();
    check("sec_cnt_saturated", sec_cnt, 16'hFFFF);

    // Clear coinciding with an SEC transfer leaves 1.
    dec_out_ready = 1'b0;
    dec_send(m_encode($urandom(), 2'd1, $urandom_range(0, 38), 0));
    guard = 0;
    do begin @(negedge clk); guard++; end while (!dec_out_valid && guard < 10);
    @(posedge clk);
    #1;
    dec_out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("sec_cnt_clr_with_sec", sec_cnt, 16'd1);
    @(posedge clk);
    #1;

    // Fill both pipelines under backpressure, then reset asynchronously.
    enc_out_ready = 1'b0;
    dec_out_ready = 1'b0;
    enc_send($urandom(), 2'd0, 6'd0, 6'd0);
    dec_send(gen_code());
    dec_send(gen_code());
    enc_in_valid = 1'b1;
    dec_in_valid = 1'b1;
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_enc_valid", enc_out_valid, 1'b0);
    check("async_rst_dec_valid", dec_out_valid, 1'b0);
    check("async_rst_cnts", {sec_cnt, ded_cnt}, 32'h0);
    check("async_rst_code", enc_out_code, 39'h0);
    enc_in_valid = 1'b0;
    dec_in_valid = 1'b0;
    enc_exp_q.delete();
    dec_exp_q.delete();
    sec_exp = '0;
    ded_exp = '0;
    enc_hold = 1'b0;
    dec_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    enc_out_ready = 1'b1;
    dec_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_enc_ready", enc_in_ready, 1'b1);
    check("post_rst_dec_ready", dec_in_ready, 1'b1);
    @(posedge clk);
    #1;
    enc_send($urandom(), 2'd0, 6'd0, 6'd0);
    dec_send(gen_code());
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1_500_000;
    fail_now("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SECDED Hamming codec for the FPGA RAM simulation models.
- Holds an encode path (data to code, registered) and a decode/correct path (code to data, 2-stage) in one block, each with valid/ready handshakes.
- Adds fault injection, correction/detection flags and saturating error counters, so RAM ECC behaviour can be driven and checked under backpressure.
- Code layout: Hamming positions 1..N-1 map to code bits 0..N-2. Power-of-two positions hold parity; the remaining positions hold data LSB-first. The overall parity bit is code bit N-1.

Parameters:
- P_DATAWIDTH, 32, data width (legal range 4..64).
- P_HAMWIDTH, derived localparam: smallest r with 2^r >= P_DATAWIDTH+r+1 (6 for 32).
- P_PARITYWIDTH, derived localparam: P_HAMWIDTH+1 (7 for 32).
- P_CODEWIDTH, derived localparam: P_DATAWIDTH+P_PARITYWIDTH (39 for 32).
- P_CNTWIDTH, 16, error counter width.
- P_POSWIDTH, derived localparam: clog2(P_CODEWIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, active-low
- enc_in_valid  in  1  encode request
- enc_in_ready  out  1  encoder can accept
- enc_in_data  in  P_DATAWIDTH  data to encode
- enc_out_valid  out  1  code valid
- enc_out_ready  in  1  consumer accepts code
- enc_out_code  out  P_CODEWIDTH  encoded word
- inj_mode  in  2  0 none, 1 single flip, 2 double flip, 3 reserved (treated as 0)
- inj_pos0  in  P_POSWIDTH  first flipped code bit index
- inj_pos1  in  P_POSWIDTH  second flipped code bit index
- dec_in_valid  in  1  decode request
- dec_in_ready  out  1  decoder can accept
- dec_in_code  in  P_CODEWIDTH  received code word
- dec_out_valid  out  1  result valid
- dec_out_ready  in  1  consumer accepts result
- dec_out_data  out  P_DATAWIDTH  corrected data
- dec_out_sec  out  1  single error corrected
- dec_out_ded  out  1  double error detected, data uncorrected
- dec_out_syndrome  out  P_HAMWIDTH  raw syndrome
- cnt_clr  in  1  synchronous clear of both counters
- sec_cnt  out  P_CNTWIDTH  corrected-error count
- ded_cnt  out  P_CNTWIDTH  uncorrectable-error count

Behaviour:
- Reset and clock: asynchronous, active-low reset rst_n; single clock clk.
- Reset values: all valid flags 0, all data/code/syndrome/flag registers 0, both counters 0. Reset mid-transfer drops in-flight words; no partial output.
- Encoder, 1 stage:
  - enc_in_ready = !enc_out_valid | enc_out_ready.
  - When enc_in_valid & enc_in_ready, the register loads on the next edge; latency 1.
  - Parity bit at position 2^k = XOR of all data positions with bit k set. Overall bit = XOR of code bits 0..N-2.
  - Injection is applied after the overall parity is computed:
    - mode 1: flip inj_pos0.
    - mode 2: flip inj_pos0 and inj_pos1. If inj_pos0 == inj_pos1, only a single flip is applied.
    - Any position >= P_CODEWIDTH is ignored.
  - enc_out_code stays stable while enc_out_valid & !enc_out_ready.
- Decoder stage 1: registers the code, syndrome s and overall parity p.
  - s = for each k, XOR of received positions with bit k set, parity positions included.
  - p = XOR of all P_CODEWIDTH bits.
- Decoder stage 2: classification.
  - s==0, p==0: clean; sec=0, ded=0.
  - p==1, s==0: overall bit in error; sec=1, data unchanged.
  - p==1, 0 < s <= P_CODEWIDTH-1: flip code bit s-1; sec=1.
  - p==1, s > P_CODEWIDTH-1: ded=1.
  - p==0, s!=0: ded=1, data extracted uncorrected.
- Decoder pipeline and handshake:
  - Latency 2 from dec_in acceptance to dec_out_valid with no stall.
  - Stage 2 loads when it is empty or dec_out_ready. Stage 1 loads when it is empty or stage 2 loads, so bubbles collapse.
  - dec_in_ready = stage-1 load enable. Full throughput is 1 word per cycle.
  - Outputs are held stable while stalled.
- Counters:
  - Increment on a dec_out transfer (valid & ready) with sec, or with ded respectively. They count each word once, never during a stall.
  - Both counters saturate at all-ones.
  - When cnt_clr coincides with a counted transfer, the counter becomes 1. cnt_clr alone sets it to 0.
- Encoder and decoder are independent; simultaneous activity on both is legal.

Decomposition:
- Package ecc_pkg holds:
  - functions calc_hamwidth(dw), is_pow2(pos) and data_pos(n), which maps data index n to a code index;
  - the injection mode constants INJ_NONE, INJ_SINGLE, INJ_DOUBLE.
- Sub-module ecc_syndrome (combinational, parametrised by P_DATAWIDTH) computes s and p.
- The encoder reuses ecc_syndrome on a word with zeroed parity slots to obtain its parity bits.

Test Plan:
- Encode 32'h00000001 with inj_mode=0 -> enc_out_code 39'h40_0000_0007, one cycle after acceptance.
- Decode 39'h40_0000_0007 with bit 5 flipped (39'h40_0000_0027) -> dec_out_data 32'h1, sec=1, ded=0, syndrome 6 after 2 cycles; sec_cnt=1.
- Encode 32'h00000001 with inj_mode=2, pos0=5, pos1=10, then decode -> ded=1, data uncorrected, ded_cnt increments by 1.
- Stream 8 words back-to-back while dec_out_ready is held low for 3 cycles mid-stream -> no loss or duplication, outputs stable while stalled, counters count each word once.
- Preset sec_cnt to 16'hFFFF via 65535 corrected words (or force), send one more -> stays 16'hFFFF. Pulse cnt_clr coincident with an SEC transfer -> sec_cnt=1.
- Assert rst_n low with both pipelines full -> all valids 0 and counters 0 immediately (asynchronous), and first accept is possible after release.
